// File: rtl/output_writeback_packer.sv
// output_writeback_packer
//   Captures one row of N_DIM_ARRAY activations per handshake, slices it into
//   MEM_DATA_WIDTH words (lowest lane in the LSBs), buffers the words in a
//   small FIFO and writes them to activation memory over a req/gnt port.
//   Word addresses run from cfg_base_addr upward (wrapping modulo 2^ADDR_WIDTH);
//   done pulses one cycle after the last word of the job is granted.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   start                         1-cycle job start, latches cfg_* (ignored while busy)
//   cfg_base_addr, cfg_num_rows   first word address, rows in job (0 = immediate done)
//   cfg_relu                      only with OUT_RELU_EN: clamp negative lanes to 0
//   in_valid, in_row, in_ready    row input handshake
//   mem_req, mem_gnt              write request / grant
//   mem_addr, mem_wdata           write address / data (FIFO head)
//   busy, done                    job active / job complete pulse
// Configuration macro: OUT_RELU_EN (adds cfg_relu port and lane clamp).
module output_writeback_packer #(
  parameter int unsigned N_DIM_ARRAY    = 16,
  parameter int unsigned ACT_DATA_WIDTH = 8,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 cfg_base_addr,
  input  logic [15:0]                           cfg_num_rows,
`ifdef OUT_RELU_EN
  input  logic                                  cfg_relu,
`endif
  input  logic                                  in_valid,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_row,
  output logic                                  in_ready,
  output logic                                  mem_req,
  input  logic                                  mem_gnt,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]             mem_wdata,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned LPW = MEM_DATA_WIDTH / ACT_DATA_WIDTH;
  localparam int unsigned WPR = N_DIM_ARRAY / LPW;
  localparam int unsigned WIW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned RW  = N_DIM_ARRAY * ACT_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PACK, S_DRAIN} state_t;

  state_t                    state;
  logic [RW-1:0]             row_reg;
  logic [RW-1:0]             row_proc;
  logic [WIW-1:0]            word_idx;
  logic [15:0]               rows_captured;
  logic [15:0]               num_rows;
  logic [ADDR_WIDTH-1:0]     base_addr;
  logic [ADDR_WIDTH-1:0]     words_granted;
  logic [MEM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW:0]               count;
  logic [MEM_DATA_WIDTH-1:0] push_word;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;
`ifdef OUT_RELU_EN
  logic                      relu_en;
`endif

  // Clamp is applied on the way into row_reg, so it costs no extra cycle.
  always_comb begin
    row_proc = in_row;
`ifdef OUT_RELU_EN
    if (relu_en) begin
      for (int unsigned k = 0; k < N_DIM_ARRAY; k++) begin
        if (in_row[k*ACT_DATA_WIDTH + ACT_DATA_WIDTH - 1]) begin
          row_proc[k*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = '0;
        end
      end
    end
`endif
  end

  always_comb begin
    push_word = '0;
    for (int unsigned w = 0; w < WPR; w++) begin
      if (word_idx == WIW'(w)) begin
        push_word = row_reg[w*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
    end
  end

  assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
  assign mem_req   = (count != '0);
  assign pop       = mem_req & mem_gnt;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign push      = (state == S_PACK) && (!fifo_full || pop);
  assign in_ready  = (state == S_CAPTURE);
  assign mem_addr  = base_addr + words_granted;
  assign mem_wdata = mem_req ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      row_reg       <= '0;
      word_idx      <= '0;
      rows_captured <= '0;
      num_rows      <= '0;
      base_addr     <= '0;
      words_granted <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
`ifdef OUT_RELU_EN
      relu_en       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (push) begin
        fifo_mem[wr_ptr] <= push_word;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        words_granted <= words_granted + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // busy is still high during the done cycle, which also blocks a restart there.
          if (start && !busy) begin
            base_addr     <= cfg_base_addr;
            num_rows      <= cfg_num_rows;
            rows_captured <= '0;
            words_granted <= '0;
            busy          <= 1'b1;
`ifdef OUT_RELU_EN
            relu_en       <= cfg_relu;
`endif
            if (cfg_num_rows == '0) done  <= 1'b1;
            else                    state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            row_reg       <= row_proc;
            word_idx      <= '0;
            rows_captured <= rows_captured + 16'd1;
            state         <= S_PACK;
          end
        end
        S_PACK: begin
          if (push) begin
            if (word_idx == WIW'(WPR - 1)) begin
              state <= (rows_captured == num_rows) ? S_DRAIN : S_CAPTURE;
            end else begin
              word_idx <= word_idx + WIW'(1);
            end
          end
        end
        S_DRAIN: begin
          // No pushes happen here, so the FIFO empties on the pop of its last entry.
          if (pop && count == (PW+1)'(1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_writeback_packer.sv
module tb_output_writeback_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  cfg_base_addr;
  logic [15:0]  cfg_num_rows;
`ifdef OUT_RELU_EN
  logic         cfg_relu;
`endif
  logic         in_valid;
  logic [127:0] in_row;
  logic         in_ready;
  logic         mem_req;
  logic         mem_gnt;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [15:0]  qa[$];
  logic [31:0]  qd[$];
  int           ncyc = 0;
  int           last_gnt = -1;
  int           done_at = -1;
  int           done_cnt = 0;

  logic [127:0] rows_buf [4];
  int           rows_sent;
  int           rows_total;

  output_writeback_packer #(
    .N_DIM_ARRAY(16), .ACT_DATA_WIDTH(8), .MEM_DATA_WIDTH(32),
    .FIFO_DEPTH(4), .ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows),
`ifdef OUT_RELU_EN
    .cfg_relu(cfg_relu),
`endif
    .in_valid(in_valid), .in_row(in_row), .in_ready(in_ready),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Records every granted write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_req && mem_gnt) begin
      qa.push_back(mem_addr);
      qd.push_back(mem_wdata);
      last_gnt = ncyc;
    end
    if (done) begin
      done_cnt++;
      done_at = ncyc;
    end
    ncyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    qa.delete();
    qd.delete();
    done_cnt = 0;
    last_gnt = -1;
    done_at  = -1;
  endtask

  function automatic logic [31:0] exp_word(input int r, input int w);
    logic [127:0] t;
    t = rows_buf[r];
    return t[w*32 +: 32];
  endfunction

  // Upstream model: holds the current row until it has been accepted.
  task automatic feed_step();
    logic hs;
    hs = in_valid && in_ready;
    cyc();
    if (hs) rows_sent++;
    if (rows_sent < rows_total) begin
      in_valid = 1'b1;
      in_row   = rows_buf[rows_sent];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic begin_job(input logic [15:0] base, input logic [15:0] nrows);
    clear_mon();
    cfg_base_addr = base;
    cfg_num_rows  = nrows;
    start = 1'b1;
    cyc();
    start      = 1'b0;
    rows_sent  = 0;
    rows_total = int'(nrows);
    if (rows_total > 0) begin
      in_valid = 1'b1;
      in_row   = rows_buf[0];
    end
  endtask

  task automatic finish_job(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      feed_step();
      i++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    cyc();
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_num_rows = '0;
    in_valid = 1'b0; in_row = '0; mem_gnt = 1'b0;
`ifdef OUT_RELU_EN
    cfg_relu = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    cyc();

    // T2: ramp row, base 0x10, grant always high
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 16; k++) rows_buf[r][k*8 +: 8] = 8'(r*16 + k);
    mem_gnt = 1'b1;
    begin_job(16'h0010, 16'd1);
    chk("t2_busy", busy, 1'b1);
    chk("t2_in_ready", in_ready, 1'b1);
    feed_step();
    chk("t2_in_ready_pack", in_ready, 1'b0);
    chk("t2_no_req_yet", mem_req, 1'b0);
    feed_step();
    chk("t2_first_req", mem_req, 1'b1);
    chk("t2_first_addr", mem_addr, 16'h0010);
    chk("t2_first_data", mem_wdata, 32'h03020100);
    finish_job("t2", 30);
    chk("t2_nwords", qa.size(), 4);
    if (qa.size() == 4) begin
      chk("t2_a0", qa[0], 16'h0010); chk("t2_d0", qd[0], 32'h03020100);
      chk("t2_a1", qa[1], 16'h0011); chk("t2_d1", qd[1], 32'h07060504);
      chk("t2_a2", qa[2], 16'h0012); chk("t2_d2", qd[2], 32'h0B0A0908);
      chk("t2_a3", qa[3], 16'h0013); chk("t2_d3", qd[3], 32'h0F0E0D0C);
    end
    chk("t2_done_lat", done_at - last_gnt, 1);
    chk("t2_done_cnt", done_cnt, 1);

    // T3: three rows with grant withheld for 20 cycles
    mem_gnt = 1'b0;
    begin_job(16'h0100, 16'd3);
    begin
      int ready_hi;
      int unstable;
      ready_hi = 0;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
        feed_step();
        if (i >= 10 && in_ready) ready_hi++;
        if (mem_req && (mem_addr !== 16'h0100 || mem_wdata !== 32'h03020100)) unstable++;
      end
      chk("t3_ready_low", ready_hi, 0);
      chk("t3_port_stable", unstable, 0);
    end
    chk("t3_rows_taken", rows_sent, 2);
    chk("t3_req_held", mem_req, 1'b1);
    chk("t3_addr_held", mem_addr, 16'h0100);
    chk("t3_data_held", mem_wdata, 32'h03020100);
    chk("t3_no_writes", qa.size(), 0);
    mem_gnt = 1'b1;
    finish_job("t3", 80);
    chk("t3_nwords", qa.size(), 12);
    if (qa.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("t3_a%0d", i), qa[i], 16'h0100 + 16'(i));
        chk($sformatf("t3_d%0d", i), qd[i], exp_word(i / 4, i % 4));
      end
    end
    chk("t3_done_cnt", done_cnt, 1);

    // T4: address wrap
    begin_job(16'hFFFE, 16'd1);
    finish_job("t4", 30);
    chk("t4_nwords", qa.size(), 4);
    if (qa.size() == 4) begin
      chk("t4_a0", qa[0], 16'hFFFE);
      chk("t4_a1", qa[1], 16'hFFFF);
      chk("t4_a2", qa[2], 16'h0000);
      chk("t4_a3", qa[3], 16'h0001);
    end

    // T5: zero-row job, then a start issued mid-job
    begin_job(16'h0030, 16'd0);
    chk("t5_done", done, 1'b1);
    chk("t5_busy", busy, 1'b1);
    chk("t5_no_req", mem_req, 1'b0);
    chk("t5_no_ready", in_ready, 1'b0);
    cyc();
    chk("t5_done_pulse", done, 1'b0);
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_no_writes", qa.size(), 0);
    begin_job(16'h0020, 16'd1);
    repeat (2) feed_step();
    cfg_base_addr = 16'h0040;
    cfg_num_rows  = 16'd5;
    start = 1'b1;
    feed_step();
    start = 1'b0;
    finish_job("t5b", 30);
    chk("t5b_nwords", qa.size(), 4);
    if (qa.size() == 4) chk("t5b_a3", qa[3], 16'h0023);
    repeat (3) cyc();
    chk("t5b_idle_req", mem_req, 1'b0);
    chk("t5b_idle_ready", in_ready, 1'b0);
    chk("t5b_done_cnt", done_cnt, 1);

`ifdef OUT_RELU_EN
    // T6: ReLU clamp on and off
    rows_buf[0] = '0;
    rows_buf[0][31:0] = 32'h017FFF80;
    cfg_relu = 1'b1;
    begin_job(16'h0000, 16'd1);
    finish_job("t6r", 30);
    if (qd.size() > 0) chk("t6_relu_on", qd[0], 32'h017F0000);
    else chk("t6_relu_on_nwords", qd.size(), 4);
    cfg_relu = 1'b0;
    begin_job(16'h0000, 16'd1);
    finish_job("t6p", 30);
    if (qd.size() > 0) chk("t6_relu_off", qd[0], 32'h017FFF80);
    else chk("t6_relu_off_nwords", qd.size(), 4);
`endif

    // T1: reset while packing
    mem_gnt = 1'b0;
    begin_job(16'h0050, 16'd2);
    repeat (3) feed_step();
    chk("t1_req_before", mem_req, 1'b1);
    reset = 1'b1;
    in_valid = 1'b0;
    rows_total = 0;
    cyc();
    reset = 1'b0;
    clear_mon();
    cyc();
    chk("t1_in_ready", in_ready, 1'b0);
    chk("t1_mem_req", mem_req, 1'b0);
    chk("t1_mem_addr", mem_addr, 16'h0);
    chk("t1_mem_wdata", mem_wdata, 32'h0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    mem_gnt = 1'b1;
    repeat (6) cyc();
    chk("t1_still_no_req", mem_req, 1'b0);
    chk("t1_no_done", done_cnt, 0);
    chk("t1_no_writes", qa.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
